// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pc_fetch_ctrl                                                 |
// | Function : Fetch-stage PC sequencer with Start/Ack handshake, LUT-based   |
// |            jump/branch targets, return-address stack and retire counter. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module pc_fetch_ctrl #(
  parameter int             D         = 12,
  parameter int             LW        = 5,
  parameter int             RAS_DEPTH = 4,
  parameter logic [D-1:0]   START_PC  = '0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Halt,
  input  logic          Stall,
  input  logic          Branch,
  input  logic          Cond,
  input  logic          Jump,
  input  logic          Call,
  input  logic          Ret,
  input  logic [LW-1:0] Lut_idx,
  input  logic [D-1:0]  Target,
  output logic [LW-1:0] Addr_lut,
  output logic [D-1:0]  PC,
  output logic          Running,
  output logic          Ack,
  output logic [15:0]   Icount,
  output logic          Ras_err
);

  localparam int           c_pw   = $clog2(RAS_DEPTH);
  localparam logic [c_pw:0] c_full = (c_pw + 1)'(RAS_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [D-1:0]    pc_q, pc_d;
  logic [15:0]     icount_q, icount_d;
  logic [c_pw:0]   ptr_q, ptr_d;
  logic [D-1:0]    ras_q [RAS_DEPTH];
  logic [D-1:0]    ras_d [RAS_DEPTH];
  logic            err_q, err_d;
  logic            running_q, running_d;
  logic            ack_q, ack_d;

  logic [D-1:0]    w_pc_inc;
  logic [c_pw:0]   w_ptr_dec;
  logic            w_ras_empty;
  logic            w_ras_full;

  assign w_pc_inc    = pc_q + D'(1);
  assign w_ptr_dec   = ptr_q - (c_pw + 1)'(1);
  assign w_ras_empty = (ptr_q == '0);
  assign w_ras_full  = (ptr_q == c_full);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    icount_d = icount_q;
    ptr_d    = ptr_q;
    ras_d    = ras_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_d  = ST_RUN;
          pc_d     = START_PC;
          icount_d = '0;
          ptr_d    = '0;
          err_d    = 1'b0;
        end
      end
      ST_RUN: begin
        // Stall freezes everything, including a decoded Halt.
        if (!Stall) begin
          if (icount_q != 16'hFFFF) begin
            icount_d = icount_q + 16'd1;
          end
          if (Halt) begin
            state_d = ST_DONE;
          end else if (Ret) begin
            if (!w_ras_empty) begin
              pc_d  = ras_q[w_ptr_dec[c_pw-1:0]];
              ptr_d = w_ptr_dec;
            end else begin
              err_d = 1'b1;
              pc_d  = w_pc_inc;
            end
          end else if (Call) begin
            pc_d = Target;
            if (!w_ras_full) begin
              ras_d[ptr_q[c_pw-1:0]] = w_pc_inc;
              ptr_d                  = ptr_q + (c_pw + 1)'(1);
            end else begin
              err_d = 1'b1;
            end
          end else if (Jump || (Branch && Cond)) begin
            pc_d = Target;
          end else begin
            pc_d = w_pc_inc;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    running_d = (state_d == ST_RUN);
    ack_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= START_PC;
      icount_q  <= '0;
      ptr_q     <= '0;
      err_q     <= 1'b0;
      running_q <= 1'b0;
      ack_q     <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      icount_q  <= icount_d;
      ptr_q     <= ptr_d;
      err_q     <= err_d;
      running_q <= running_d;
      ack_q     <= ack_d;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= ras_d[i];
      end
    end
  end

  assign Addr_lut = Lut_idx;
  assign PC       = pc_q;
  assign Running  = running_q;
  assign Ack      = ack_q;
  assign Icount   = icount_q;
  assign Ras_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pc_fetch_ctrl                                              |
// | Function : Table-driven self-checking bench for pc_fetch_ctrl.           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_pc_fetch_ctrl;

  localparam logic [7:0] c_none  = 8'h00;
  localparam logic [7:0] c_start = 8'h80;
  localparam logic [7:0] c_halt  = 8'h40;
  localparam logic [7:0] c_stall = 8'h20;
  localparam logic [7:0] c_br    = 8'h10;
  localparam logic [7:0] c_cond  = 8'h08;
  localparam logic [7:0] c_jmp   = 8'h04;
  localparam logic [7:0] c_call  = 8'h02;
  localparam logic [7:0] c_ret   = 8'h01;

  typedef struct {
    logic [7:0]  ctrl;
    logic [4:0]  idx;
    logic [11:0] pc;
    logic        run;
    logic        ack;
    logic [15:0] ic;
    logic        err;
  } vec_t;

  logic        Clk, Reset, Start, Halt, Stall, Branch, Cond, Jump, Call, Ret;
  logic [4:0]  Lut_idx, Addr_lut;
  logic [11:0] Target, PC;
  logic        Running, Ack, Ras_err;
  logic [15:0] Icount;

  int n_pass = 0;
  int n_total = 0;
  vec_t vq[$];

  pc_fetch_ctrl #(.D(12), .LW(5), .RAS_DEPTH(4), .START_PC(12'd0)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
    .Branch(Branch), .Cond(Cond), .Jump(Jump), .Call(Call), .Ret(Ret),
    .Lut_idx(Lut_idx), .Target(Target), .Addr_lut(Addr_lut), .PC(PC),
    .Running(Running), .Ack(Ack), .Icount(Icount), .Ras_err(Ras_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [11:0] lut(input logic [4:0] i);
    case (i)
      5'd0:    lut = 12'd7;
      5'd1:    lut = 12'd206;
      5'd2:    lut = 12'd3;
      5'd3:    lut = 12'd10;
      5'd4:    lut = 12'd4095;
      5'd5:    lut = 12'd9;
      5'd6:    lut = 12'd37;
      5'd12:   lut = 12'd22;
      default: lut = 12'h0AA;
    endcase
  endfunction

  assign Target = lut(Addr_lut);

  function automatic vec_t mk(input logic [7:0] c, input logic [4:0] i,
                              input int pc, input logic run, input logic ack,
                              input int ic, input logic err);
    vec_t v;
    v.ctrl = c; v.idx = i; v.pc = 12'(pc); v.run = run; v.ack = ack;
    v.ic = 16'(ic); v.err = err;
    return v;
  endfunction

  task automatic drive(input logic [7:0] c, input logic [4:0] i);
    {Start, Halt, Stall, Branch, Cond, Jump, Call, Ret} = c;
    Lut_idx = i;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // {Addr_lut, PC, Running, Ack, Icount, Ras_err}
  function automatic logic [63:0] pack_out();
    return 64'({Addr_lut, PC, Running, Ack, Icount, Ras_err});
  endfunction

  function automatic logic [63:0] pack_exp(input logic [4:0] i, input logic [11:0] pc,
                                          input logic run, input logic ack,
                                          input logic [15:0] ic, input logic err);
    return 64'({i, pc, run, ack, ic, err});
  endfunction

  initial begin
    // Hand-computed expectations; bench LUT: 0->7 1->206 2->3 3->10 4->4095 5->9 6->37 12->22
    vq.push_back(mk(c_start, 0,   0, 1, 0,  0, 0));
    vq.push_back(mk(c_none,  0,   1, 1, 0,  1, 0));
    vq.push_back(mk(c_none,  0,   2, 1, 0,  2, 0));
    vq.push_back(mk(c_none,  0,   3, 1, 0,  3, 0));
    vq.push_back(mk(c_none,  0,   4, 1, 0,  4, 0));
    vq.push_back(mk(c_none,  0,   5, 1, 0,  5, 0));
    vq.push_back(mk(c_halt,  0,   5, 0, 1,  6, 0));
    vq.push_back(mk(c_jmp,   1,   5, 0, 1,  6, 0));
    vq.push_back(mk(c_start, 0,   0, 1, 0,  0, 0));
    vq.push_back(mk(c_none,  0,   1, 1, 0,  1, 0));
    vq.push_back(mk(c_none,  0,   2, 1, 0,  2, 0));
    vq.push_back(mk(c_none,  0,   3, 1, 0,  3, 0));
    vq.push_back(mk(c_jmp,   1, 206, 1, 0,  4, 0));
    vq.push_back(mk(c_jmp,   2,   3, 1, 0,  5, 0));
    vq.push_back(mk(c_br,   12,   4, 1, 0,  6, 0));
    vq.push_back(mk(c_jmp,   2,   3, 1, 0,  7, 0));
    vq.push_back(mk(c_br | c_cond, 12, 22, 1, 0, 8, 0));
    vq.push_back(mk(c_jmp,   2,   3, 1, 0,  9, 0));
    vq.push_back(mk(c_jmp | c_br | c_cond, 0, 7, 1, 0, 10, 0));
    vq.push_back(mk(c_jmp,   3,  10, 1, 0, 11, 0));
    vq.push_back(mk(c_call,  0,   7, 1, 0, 12, 0));
    vq.push_back(mk(c_none,  0,   8, 1, 0, 13, 0));
    vq.push_back(mk(c_none,  0,   9, 1, 0, 14, 0));
    vq.push_back(mk(c_call, 12,  22, 1, 0, 15, 0));
    vq.push_back(mk(c_ret,   0,  10, 1, 0, 16, 0));
    vq.push_back(mk(c_ret,   0,  11, 1, 0, 17, 0));
    vq.push_back(mk(c_ret,   0,  12, 1, 0, 18, 1));
    vq.push_back(mk(c_halt,  0,  12, 0, 1, 19, 1));
    vq.push_back(mk(c_start, 0,   0, 1, 0,  0, 0));
    vq.push_back(mk(c_call,  3,  10, 1, 0,  1, 0));
    vq.push_back(mk(c_call,  0,   7, 1, 0,  2, 0));
    vq.push_back(mk(c_call,  5,   9, 1, 0,  3, 0));
    vq.push_back(mk(c_call,  1, 206, 1, 0,  4, 0));
    vq.push_back(mk(c_call,  2,   3, 1, 0,  5, 1));
    vq.push_back(mk(c_ret,   0,  10, 1, 0,  6, 1));
    vq.push_back(mk(c_ret,   0,   8, 1, 0,  7, 1));
    vq.push_back(mk(c_ret,   0,  11, 1, 0,  8, 1));
    vq.push_back(mk(c_ret,   0,   1, 1, 0,  9, 1));
    vq.push_back(mk(c_ret,   0,   2, 1, 0, 10, 1));
    vq.push_back(mk(c_stall | c_halt | c_jmp, 4, 2, 1, 0, 10, 1));
    vq.push_back(mk(c_stall | c_halt | c_jmp, 4, 2, 1, 0, 10, 1));
    vq.push_back(mk(c_stall | c_halt | c_jmp, 4, 2, 1, 0, 10, 1));
    vq.push_back(mk(c_jmp,   4, 4095, 1, 0, 11, 1));
    vq.push_back(mk(c_none,  0,   0, 1, 0, 12, 1));
    vq.push_back(mk(c_start, 0,   1, 1, 0, 13, 1));
    vq.push_back(mk(c_ret | c_call | c_jmp, 1, 2, 1, 0, 14, 1));
    vq.push_back(mk(c_call | c_jmp, 4, 4095, 1, 0, 15, 1));
    vq.push_back(mk(c_ret,   0,   3, 1, 0, 16, 1));
    vq.push_back(mk(c_jmp,   4, 4095, 1, 0, 17, 1));
    vq.push_back(mk(c_call,  2,   3, 1, 0, 18, 1));
    vq.push_back(mk(c_ret,   0,   0, 1, 0, 19, 1));
    vq.push_back(mk(c_jmp,   6,  37, 1, 0, 20, 1));

    drive(c_none, 5'd0);
    Reset = 1'b0;
    #1;
    check("reset_state", pack_out(), pack_exp(5'd0, 12'd0, 1'b0, 1'b0, 16'd0, 1'b0));
    #1 Reset = 1'b1;

    for (int k = 0; k < vq.size(); k++) begin
      drive(vq[k].ctrl, vq[k].idx);
      @(posedge Clk);
      #1;
      check($sformatf("vec%0d", k), pack_out(),
            pack_exp(vq[k].idx, vq[k].pc, vq[k].run, vq[k].ack, vq[k].ic, vq[k].err));
    end

    // Asynchronous reset mid-run at PC=37, checked before the next edge.
    drive(c_jmp, 5'd6);
    #2 Reset = 1'b0;
    #1;
    check("async_reset", pack_out(), pack_exp(5'd6, 12'd0, 1'b0, 1'b0, 16'd0, 1'b0));
    #2 Reset = 1'b1;
    drive(c_none, 5'd0);
    @(posedge Clk);
    #1;
    check("idle_after_reset", pack_out(), pack_exp(5'd0, 12'd0, 1'b0, 1'b0, 16'd0, 1'b0));
    drive(c_start, 5'd0);
    @(posedge Clk);
    #1;
    check("restart", pack_out(), pack_exp(5'd0, 12'd0, 1'b1, 1'b0, 16'd0, 1'b0));

    // Retire counter saturation over a long straight-line run.
    drive(c_none, 5'd0);
    repeat (65534) @(posedge Clk);
    #1;
    check("icount_65534", 64'(Icount), 64'(16'd65534));
    @(posedge Clk);
    #1;
    check("icount_65535", 64'(Icount), 64'(16'hFFFF));
    @(posedge Clk);
    #1;
    check("icount_sat", 64'({Running, Icount}), 64'({1'b1, 16'hFFFF}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
